// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired micro-sequencer for the 8-bit datapath. It accepts one
// instruction over a valid/ready handshake, steps through that opcode's
// register transfers by driving the load strobes, bus-output selects and the
// R1 write enable, and pulses done in the final cycle of each instruction.
// It also holds the immediate operand presented to the RA load input.
//
// Optional feature macro: SEQ_PERF_EN
//   When defined, adds a 16-bit instr_count output that counts completed
//   non-NOP instructions (wraps at 0xFFFF, cleared by reset).
//
// Ports:
//   clock        in   rising-edge system clock
//   clear        in   synchronous active-low reset
//   instr_valid  in   instruction present on instr_op/instr_imm
//   instr_ready  out  sequencer can accept an instruction (IDLE only)
//   instr_op     in   [1:0] opcode: 00 NOP, 01 LDA, 10 LDB, 11 ADD
//   instr_imm    in   [7:0] immediate operand for LDA
//   imm_out      out  [7:0] immediate to datapath RA load input
//   ra_in        out  RA load strobe
//   rb_in        out  RB load strobe
//   rz_in        out  RZ load strobe
//   ra_out       out  RA drives bus
//   rb_out       out  RB drives bus
//   rz_out       out  RZ drives bus
//   r1_we        out  R1 write enable
//   busy         out  instruction in progress
//   done         out  one-cycle completion pulse
//   instr_count  out  [15:0] completed non-NOP count (SEQ_PERF_EN only)

module control_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [1:0] instr_op,
    input  logic [7:0] instr_imm,
    output logic [7:0] imm_out,
    output logic       ra_in,
    output logic       rb_in,
    output logic       rz_in,
    output logic       ra_out,
    output logic       rb_out,
    output logic       rz_out,
    output logic       r1_we,
    output logic       busy,
    output logic       done
`ifdef SEQ_PERF_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDA   = 3'd1,
        S_LDB   = 3'd2,
        S_ADD_X = 3'd3,
        S_ADD_W = 3'd4,
        S_NOP   = 3'd5
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDA = 2'b01;
    localparam logic [1:0] OP_LDB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    state_t     state;
    state_t     next_state;
    logic       accept;
    logic [7:0] imm_q;

    // instr_ready is decoded from state only, so accept has no
    // combinational path back into the handshake.
    assign accept  = instr_valid && instr_ready;
    assign imm_out = imm_q;

    // State register; reset always lands in IDLE.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Immediate holding register: only an accepted LDA replaces it, so the
    // value stays stable for the RA load in the following cycle and beyond.
    always_ff @(posedge clock) begin
        if (!clear) begin
            imm_q <= 8'h00;
        end else if (accept && (instr_op == OP_LDA)) begin
            imm_q <= instr_imm;
        end
    end

    // Next-state decode and Moore outputs. Every output defaults low so the
    // illegal encodings fall through to "all strobes off, go to IDLE".
    always_comb begin
        next_state  = S_IDLE;
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ra_in       = 1'b0;
        rb_in       = 1'b0;
        rz_in       = 1'b0;
        ra_out      = 1'b0;
        rb_out      = 1'b0;
        rz_out      = 1'b0;
        r1_we       = 1'b0;

        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                next_state  = S_IDLE;
                if (instr_valid) begin
                    case (instr_op)
                        OP_NOP:  next_state = S_NOP;
                        OP_LDA:  next_state = S_LDA;
                        OP_LDB:  next_state = S_LDB;
                        OP_ADD:  next_state = S_ADD_X;
                        default: next_state = S_IDLE;
                    endcase
                end
            end
            S_LDA: begin
                busy  = 1'b1;
                done  = 1'b1;
                ra_in = 1'b1;
            end
            S_LDB: begin
                busy   = 1'b1;
                done   = 1'b1;
                ra_out = 1'b1;
                rb_in  = 1'b1;
            end
            S_ADD_X: begin
                // RA feeds the adder directly; RB supplies the bus operand.
                busy       = 1'b1;
                rb_out     = 1'b1;
                rz_in      = 1'b1;
                next_state = S_ADD_W;
            end
            S_ADD_W: begin
                busy   = 1'b1;
                done   = 1'b1;
                rz_out = 1'b1;
                r1_we  = 1'b1;
            end
            S_NOP: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_PERF_EN
    logic [15:0] count_q;

    // Counts done cycles of LDA, LDB and ADD; NOP completions are skipped.
    always_ff @(posedge clock) begin
        if (!clear) begin
            count_q <= 16'h0000;
        end else if ((state == S_LDA) || (state == S_LDB) || (state == S_ADD_W)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. A table of instructions is
// issued one at a time; for each one the expected per-cycle control word and
// imm_out are pushed to a scoreboard queue when the instruction is driven and
// popped/compared on each following falling edge. A small datapath model
// (RA, RB, RZ, R1) follows the strobes so the ADD result can be checked.
// Hand-written sequences cover reset, the held-valid handshake, abort by
// reset and (when SEQ_PERF_EN is defined) the instruction counter.

module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic [7:0]  instr_imm;
    logic [7:0]  imm_out;
    logic        ra_in;
    logic        rb_in;
    logic        rz_in;
    logic        ra_out;
    logic        rb_out;
    logic        rz_out;
    logic        r1_we;
    logic        busy;
    logic        done;
`ifdef SEQ_PERF_EN
    logic [15:0] instr_count;
`endif

    control_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .imm_out     (imm_out),
        .ra_in       (ra_in),
        .rb_in       (rb_in),
        .rz_in       (rz_in),
        .ra_out      (ra_out),
        .rb_out      (rb_out),
        .rz_out      (rz_out),
        .r1_we       (r1_we),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_PERF_EN
        ,
        .instr_count (instr_count)
`endif
    );

    // Control word: {instr_ready, busy, done, ra_in, rb_in, rz_in, ra_out, rb_out, rz_out, r1_we}
    localparam logic [9:0] CW_IDLE  = 10'b1_0_0_000_000_0;
    localparam logic [9:0] CW_LDA   = 10'b0_1_1_100_000_0;
    localparam logic [9:0] CW_LDB   = 10'b0_1_1_010_100_0;
    localparam logic [9:0] CW_ADD_X = 10'b0_1_0_001_010_0;
    localparam logic [9:0] CW_ADD_W = 10'b0_1_1_000_001_1;
    localparam logic [9:0] CW_NOP   = 10'b0_1_1_000_000_0;

    typedef struct {
        logic [9:0] ctl;
        logic [7:0] imm;
        string      tag;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] imm;
        logic [7:0] exp_imm;
    } vec_t;

    exp_t       sb[$];
    int         checks;
    int         failures;
    logic [7:0] model_imm;
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [7:0] reg_z;
    logic [7:0] reg_r1;
    int         accept_seen;
    int         done_seen;
    int         r1we_seen;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural datapath driven by the sequencer strobes.
    always @(posedge clock) begin
        logic [7:0] bus;
        bus = ra_out ? reg_a : (rb_out ? reg_b : (rz_out ? reg_z : 8'h00));
        if (ra_in) reg_a  <= imm_out;
        if (rb_in) reg_b  <= bus;
        if (rz_in) reg_z  <= reg_a + bus;
        if (r1_we) reg_r1 <= bus;
    end

    // Event counters for the handshake and abort sequences.
    always @(posedge clock) begin
        if (instr_valid && instr_ready && clear) accept_seen <= accept_seen + 1;
        if (done)  done_seen <= done_seen + 1;
        if (r1_we) r1we_seen <= r1we_seen + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [9:0] act;
        act = {instr_ready, busy, done, ra_in, rb_in, rz_in, ra_out, rb_out, rz_out, r1_we};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got ctl=%b, want an expectation", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.ctl) begin
                failures++;
                $display("[TB] FAIL %s ctl: got %b, want %b", e.tag, act, e.ctl);
            end
            checks++;
            if (imm_out !== e.imm) begin
                failures++;
                $display("[TB] FAIL %s imm_out: got %h, want %h", e.tag, imm_out, e.imm);
            end
        end
    endtask

    task automatic pushExp(input logic [9:0] ctl, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.imm = model_imm;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Queue the cycles that follow an accept edge, ending with the IDLE cycle.
    task automatic pushInstr(input logic [1:0] op, input logic [7:0] imm);
        case (op)
            2'b00: pushExp(CW_NOP, "nop");
            2'b01: begin
                model_imm = imm;
                pushExp(CW_LDA, "lda");
            end
            2'b10: pushExp(CW_LDB, "ldb");
            default: begin
                pushExp(CW_ADD_X, "add_x");
                pushExp(CW_ADD_W, "add_w");
            end
        endcase
        pushExp(CW_IDLE, "idle_after");
    endtask

    // Called just after a falling edge with the sequencer in IDLE.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] imm);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        pushInstr(op, imm);
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instr_imm   = 8'hC3;
    endtask

    task automatic drainScoreboard();
        for (int n = 0; n < 8 && sb.size() > 0; n++) begin
            @(negedge clock);
            checkOutput();
        end
        checkValue("drain_empty", 16'(sb.size()), 16'd0);
    endtask

    vec_t vecs[9];

    initial begin
        checks      = 0;
        failures    = 0;
        model_imm   = 8'h00;
        accept_seen = 0;
        done_seen   = 0;
        r1we_seen   = 0;
        reg_a       = 8'h00;
        reg_b       = 8'h00;
        reg_z       = 8'h00;
        reg_r1      = 8'h00;

        vecs[0] = '{op: 2'b00, imm: 8'h11, exp_imm: 8'h00};
        vecs[1] = '{op: 2'b01, imm: 8'h5A, exp_imm: 8'h5A};
        vecs[2] = '{op: 2'b10, imm: 8'h77, exp_imm: 8'h5A};
        vecs[3] = '{op: 2'b11, imm: 8'h99, exp_imm: 8'h5A};
        vecs[4] = '{op: 2'b01, imm: 8'h20, exp_imm: 8'h20};
        vecs[5] = '{op: 2'b10, imm: 8'hEE, exp_imm: 8'h20};
        vecs[6] = '{op: 2'b01, imm: 8'hF0, exp_imm: 8'hF0};
        vecs[7] = '{op: 2'b11, imm: 8'h01, exp_imm: 8'hF0};
        vecs[8] = '{op: 2'b00, imm: 8'h42, exp_imm: 8'hF0};

        // Reset held for two edges with a valid LDA pending: it must not load.
        clear       = 1'b0;
        instr_valid = 1'b1;
        instr_op    = 2'b01;
        instr_imm   = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            pushExp(CW_IDLE, "reset_hold");
            checkOutput();
        end
        clear       = 1'b1;
        instr_valid = 1'b0;
        @(negedge clock);
        pushExp(CW_IDLE, "reset_release");
        checkOutput();

        // Table-driven instruction stream.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].op, vecs[v].imm);
            drainScoreboard();
            checkValue($sformatf("vec%0d_imm", v), {8'h00, imm_out}, {8'h00, vecs[v].exp_imm});
        end
        checkValue("ldb_rb_from_ra", {8'h00, reg_b}, 16'h0020);
        checkValue("add_rz_wrap", {8'h00, reg_z}, 16'h0010);
        checkValue("add_r1_wrap", {8'h00, reg_r1}, 16'h0010);

        // ADD held valid continuously: one accept every three cycles.
        accept_seen = 0;
        done_seen   = 0;
        instr_valid = 1'b1;
        instr_op    = 2'b11;
        for (int k = 0; k < 3; k++) pushInstr(2'b11, 8'h00);
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            checkOutput();
        end
        instr_valid = 1'b0;
        checkValue("held_valid_accepts", 16'(accept_seen), 16'd3);
        checkValue("held_valid_dones", 16'(done_seen), 16'd3);

        // Reset during ADD_X aborts: no r1_we, no done, IDLE next cycle.
        instr_valid = 1'b1;
        instr_op    = 2'b11;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(negedge clock);
        pushExp(CW_ADD_X, "abort_add_x");
        checkOutput();
        clear     = 1'b0;
        done_seen = 0;
        r1we_seen = 0;
        model_imm = 8'h00;
        @(negedge clock);
        pushExp(CW_IDLE, "abort_idle");
        checkOutput();
        clear = 1'b1;
        @(negedge clock);
        pushExp(CW_IDLE, "abort_after");
        checkOutput();
        checkValue("abort_r1we", 16'(r1we_seen), 16'd0);
        checkValue("abort_done", 16'(done_seen), 16'd0);

`ifdef SEQ_PERF_EN
        checkValue("perf_after_reset", instr_count, 16'h0000);
        applyStimulus(2'b11, 8'h00); drainScoreboard();
        applyStimulus(2'b00, 8'h00); drainScoreboard();
        applyStimulus(2'b11, 8'h00); drainScoreboard();
        applyStimulus(2'b00, 8'h00); drainScoreboard();
        applyStimulus(2'b11, 8'h00); drainScoreboard();
        checkValue("perf_count3", instr_count, 16'd3);
        force dut.count_q = 16'hFFFF;
        @(negedge clock);
        release dut.count_q;
        applyStimulus(2'b11, 8'h00); drainScoreboard();
        checkValue("perf_wrap", instr_count, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
